stream_accumulator: RTL

STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

---
 rtl/stream_accumulator_if.sv | 26 ++
 rtl/stream_accumulator.sv | 96 +++++++++
 2 files changed

// File: rtl/stream_accumulator_if.sv
// Stream bundle for the accumulator: word input side (din_*) and result output side (dout_*).
// The accumulator uses the slave view; the producer/consumer uses the master view.
interface stream_accumulator_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] din_data;
    logic                  din_last;
    logic                  din_vld;
    logic                  din_rd;
    logic [ACC_WIDTH-1:0]  dout_data;
    logic                  dout_ovf;
    logic [7:0]            dout_cnt;
    logic                  dout_vld;
    logic                  dout_rd;

    modport slave (
        input  din_data, din_last, din_vld, dout_rd,
        output din_rd, dout_data, dout_ovf, dout_cnt, dout_vld
    );

    modport master (
        output din_data, din_last, din_vld, dout_rd,
        input  din_rd, dout_data, dout_ovf, dout_cnt, dout_vld
    );
endinterface

// File: rtl/stream_accumulator.sv
// Frame accumulator: sums unsigned words until din_last, then holds sum/overflow/count
// until the consumer takes it.
module stream_accumulator #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_accumulator_if.slave   bus
);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic                 ovf_reg, ovf_next;
    logic [7:0]           cnt_reg, cnt_next;

    logic [ACC_WIDTH-1:0] din_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH:0]   carry;
    logic                 din_rd_c;
    logic                 dout_vld_c;

    assign din_ext  = ACC_WIDTH'(bus.din_data);
    assign carry[0] = 1'b0;

    // Explicit ripple-carry chain; carry[ACC_WIDTH] is the overflow of this addition.
    generate
        for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_ripple
            assign sum[gi]      = acc_reg[gi] ^ din_ext[gi] ^ carry[gi];
            assign carry[gi+1]  = (acc_reg[gi] & din_ext[gi]) |
                                  (carry[gi] & (acc_reg[gi] ^ din_ext[gi]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        din_rd_c   = 1'b0;
        dout_vld_c = 1'b0;
        case (state_reg)
            ACC: begin
                din_rd_c = 1'b1;
                if (bus.din_vld) begin
                    acc_next = sum;
                    ovf_next = ovf_reg | carry[ACC_WIDTH];
                    cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
                    if (bus.din_last) begin
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                dout_vld_c = 1'b1;
                // din_rd is a pure function of state, so a taken result frees the
                // input only on the following cycle.
                if (bus.dout_rd) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    assign bus.din_rd    = din_rd_c;
    assign bus.dout_vld  = dout_vld_c;
    assign bus.dout_data = acc_reg;
    assign bus.dout_ovf  = ovf_reg;
    assign bus.dout_cnt  = cnt_reg;

endmodule
